// File: rtl/abc_pkg.sv
// Shared types for the a/b/c sequence checker: state and error encodings.
package abc_pkg;

  localparam int W_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_C    = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    INIT_NONZERO = 3'd1,
    BAD_STEP     = 3'd2,
    IDLE_MOVED   = 3'd3,
    OVERRUN      = 3'd4
  } err_t;

endpackage

// File: rtl/abc_step_check.sv
// Per-counter step classifier: a legal +1 step when active, any change when idle.
module abc_step_check #(
  parameter int W = abc_pkg::W_DEF
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] prev,
  input  logic         active,
  output logic         ok_step,
  output logic         moved
);

  logic [W-1:0] prev_inc;

  // Increment wraps modulo 2**W by construction of the W-bit result.
  assign prev_inc = prev + W'(1);
  assign ok_step  = active && (cur == prev_inc);
  assign moved    = !active && (cur != prev);

endmodule

// File: rtl/abc_seq_checker.sv
// Consumer-side monitor for the a/b/c sequencer bus: tracks phase, flags the
// first ordering violation (sticky) and counts accepted steps.
module abc_seq_checker
  import abc_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int A_LAST = 5,
  parameter int B_LAST = 6,
  parameter int C_LAST = 7,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  output logic [2:0]       phase,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] step_cnt
);

  state_t       state;
  err_t         code;
  logic [W-1:0] prev_a, prev_b, prev_c;

  logic act_a, act_b, act_c;
  logic ok_a, ok_b, ok_c;
  logic mv_a, mv_b, mv_c;
  logic bad_step, any_moved, land;
  state_t land_state;

  assign act_a = (state == S_A);
  assign act_b = (state == S_B);
  assign act_c = (state == S_C);

  abc_step_check #(.W(W)) u_chk_a (.cur(a), .prev(prev_a), .active(act_a), .ok_step(ok_a), .moved(mv_a));
  abc_step_check #(.W(W)) u_chk_b (.cur(b), .prev(prev_b), .active(act_b), .ok_step(ok_b), .moved(mv_b));
  abc_step_check #(.W(W)) u_chk_c (.cur(c), .prev(prev_c), .active(act_c), .ok_step(ok_c), .moved(mv_c));

  // Classify the current sample; a mis-step on the active counter outranks idle motion.
  always_comb begin
    bad_step   = (act_a && !ok_a) || (act_b && !ok_b) || (act_c && !ok_c);
    any_moved  = mv_a || mv_b || mv_c;
    land       = 1'b0;
    land_state = state;
    unique case (state)
      S_A: begin land = (a == W'(A_LAST)); land_state = S_B;    end
      S_B: begin land = (b == W'(B_LAST)); land_state = S_C;    end
      S_C: begin land = (c == W'(C_LAST)); land_state = S_DONE; end
      default: ;
    endcase
  end

  // Checker FSM with registered status outputs; S_ERR only exits via reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      code     <= NONE;
      done     <= 1'b0;
      err      <= 1'b0;
      step_cnt <= '0;
      prev_a   <= '0;
      prev_b   <= '0;
      prev_c   <= '0;
    end else begin
      prev_a <= a;
      prev_b <= b;
      prev_c <= c;
      unique case (state)
        S_IDLE: begin
          if ((a != '0) || (b != '0) || (c != '0)) begin
            state <= S_ERR;
            code  <= INIT_NONZERO;
            err   <= 1'b1;
          end else begin
            state <= S_A;
          end
        end
        S_A, S_B, S_C: begin
          if (bad_step) begin
            state <= S_ERR;
            code  <= BAD_STEP;
            err   <= 1'b1;
          end else if (any_moved) begin
            state <= S_ERR;
            code  <= IDLE_MOVED;
            err   <= 1'b1;
          end else begin
            if (step_cnt != '1) step_cnt <= step_cnt + CNT_W'(1);
            if (land) begin
              state <= land_state;
              done  <= (land_state == S_DONE);
            end
          end
        end
        S_DONE: begin
          if (any_moved) begin
            state <= S_ERR;
            code  <= OVERRUN;
            err   <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase    = state;
  assign err_code = code;

endmodule

// File: tb/tb_abc_seq_checker.sv
// Directed and randomized bench for abc_seq_checker against a step-count model.
module tb_abc_seq_checker;

  localparam int A_LAST = 5;
  localparam int B_LAST = 6;
  localparam int C_LAST = 7;
  localparam int N_A    = A_LAST;
  localparam int N_B    = A_LAST + B_LAST;
  localparam int N_T    = A_LAST + B_LAST + C_LAST;

  logic       clk;
  logic       reset;
  logic [2:0] a, b, c;
  logic [2:0] phase;
  logic       done, err;
  logic [2:0] err_code;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;

  // Model: progress is just "started" plus number of accepted steps.
  int m_started, m_steps, m_err;
  int pa, pb, pc;

  abc_seq_checker #(.W(3), .A_LAST(A_LAST), .B_LAST(B_LAST), .C_LAST(C_LAST), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
    .phase(phase), .done(done), .err(err), .err_code(err_code), .step_cnt(step_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_started = 0; m_steps = 0; m_err = 0;
    pa = 0; pb = 0; pc = 0;
  endtask

  task automatic model_step(input int na, input int nb, input int nc);
    int cur[3];
    int prv[3];
    int idx;
    cur[0] = na; cur[1] = nb; cur[2] = nc;
    prv[0] = pa; prv[1] = pb; prv[2] = pc;
    if (m_err == 0) begin
      if (m_started == 0) begin
        m_started = 1;
        if (na != 0 || nb != 0 || nc != 0) m_err = 1;
      end else if (m_steps == N_T) begin
        if (na != pa || nb != pb || nc != pc) m_err = 4;
      end else begin
        idx = (m_steps < N_A) ? 0 : (m_steps < N_B) ? 1 : 2;
        if (cur[idx] != (prv[idx] + 1) % 8) m_err = 2;
        else begin
          for (int i = 0; i < 3; i++)
            if (i != idx && cur[i] != prv[i]) m_err = 3;
          if (m_err == 0) m_steps++;
        end
      end
    end
    pa = na; pb = nb; pc = nc;
  endtask

  function automatic int exp_phase();
    if (m_err != 0)       return 5;
    if (m_started == 0)   return 0;
    if (m_steps < N_A)    return 1;
    if (m_steps < N_B)    return 2;
    if (m_steps < N_T)    return 3;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"},    32'(phase),    32'(exp_phase()));
    chk({tag, ".done"},     32'(done),     32'(exp_phase() == 4));
    chk({tag, ".err"},      32'(err),      32'(m_err != 0));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_err));
    chk({tag, ".step_cnt"}, 32'(step_cnt), 32'(m_steps));
  endtask

  // Called at a negedge: present a sample, let the edge take it, check, return at negedge.
  task automatic drive(input string tag, input int na, input int nb, input int nc);
    a = 3'(na); b = 3'(nb); c = 3'(nc);
    model_step(na, nb, nc);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    a = '0; b = '0; c = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic nominal(input string tag);
    drive(tag, 0, 0, 0);
    for (int i = 1; i <= A_LAST; i++) drive(tag, i, 0, 0);
    for (int i = 1; i <= B_LAST; i++) drive(tag, A_LAST, i, 0);
    for (int i = 1; i <= C_LAST; i++) drive(tag, A_LAST, B_LAST, i);
  endtask

  // Next legal sample according to the model's progress.
  task automatic legal_next(output int na, output int nb, output int nc);
    na = pa; nb = pb; nc = pc;
    if (m_started == 0) begin na = 0; nb = 0; nc = 0; end
    else if (m_steps < N_A) na = (pa + 1) % 8;
    else if (m_steps < N_B) nb = (pb + 1) % 8;
    else if (m_steps < N_T) nc = (pc + 1) % 8;
  endtask

  initial begin
    int na, nb, nc, r;
    reset = 1'b0;
    a = '0; b = '0; c = '0;
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Nominal run, then hold in done.
    nominal("nominal");
    chk("nominal.final_cnt", 32'(step_cnt), 32'd18);
    chk("nominal.final_done", 32'(done), 32'd1);
    drive("hold", A_LAST, B_LAST, C_LAST);
    drive("hold", A_LAST, B_LAST, C_LAST);

    // Overrun after completion.
    drive("overrun", A_LAST, B_LAST, 0);
    chk("overrun.code", 32'(err_code), 32'd4);
    drive("overrun_after", 1, 2, 3);

    // Nonzero start.
    do_reset();
    drive("init_nz", 1, 0, 0);
    chk("init_nz.code", 32'(err_code), 32'd1);

    // Skip in a: 0,1,2,4 then later activity is ignored.
    do_reset();
    drive("skip", 0, 0, 0);
    drive("skip", 1, 0, 0);
    drive("skip", 2, 0, 0);
    drive("skip", 4, 0, 0);
    chk("skip.cnt", 32'(step_cnt), 32'd2);
    drive("skip_after", 5, 0, 0);
    drive("skip_after", 0, 0, 0);

    // Idle counter moves with a correct active step.
    do_reset();
    drive("idle_mv", 0, 0, 0);
    drive("idle_mv", 1, 0, 0);
    drive("idle_mv", 2, 0, 0);
    drive("idle_mv", 3, 1, 0);
    chk("idle_mv.code", 32'(err_code), 32'd3);

    // Idle counter moves while active also mis-steps: BAD_STEP wins.
    do_reset();
    drive("both", 0, 0, 0);
    drive("both", 1, 0, 0);
    drive("both", 2, 0, 0);
    drive("both", 4, 1, 0);
    chk("both.code", 32'(err_code), 32'd2);

    // Stall on the active counter.
    do_reset();
    drive("stall", 0, 0, 0);
    drive("stall", 1, 0, 0);
    drive("stall", 1, 0, 0);

    // Async reset in the middle of the b phase.
    do_reset();
    drive("mid", 0, 0, 0);
    for (int i = 1; i <= A_LAST; i++) drive("mid", i, 0, 0);
    drive("mid", A_LAST, 1, 0);
    drive("mid", A_LAST, 2, 0);
    chk("mid.phase_b", 32'(phase), 32'd2);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    a = '0; b = '0; c = '0;
    reset = 1'b1;
    nominal("rerun");
    chk("rerun.cnt", 32'(step_cnt), 32'd18);

    // Randomized runs: mostly legal, occasionally perturbed.
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int n = 0; n < 24; n++) begin
        legal_next(na, nb, nc);
        r = int'($urandom_range(0, 29));
        if (r == 0) begin
          na = int'($urandom_range(0, 7));
          nb = int'($urandom_range(0, 7));
          nc = int'($urandom_range(0, 7));
        end else if (r == 1) na = int'($urandom_range(0, 7));
        else if (r == 2) nb = int'($urandom_range(0, 7));
        else if (r == 3) nc = int'($urandom_range(0, 7));
        drive("rand", na, nb, nc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/abc_seq_checker.md
Name: abc_seq_checker

Overview:
- Consumer-side sequence checker for the three-counter a/b/c sequencer bus.
- Samples a, b, c every cycle and verifies the required order: a steps 0 to A_LAST, then b steps 0 to B_LAST, then c steps 0 to C_LAST, then all three hold.
- Reports the current phase, completion, a sticky first-error code, and an accepted-step count.
- Sits beside the sequencer as an in-design monitor and is reused as a bench scoreboard.

Parameters:
- W, 3, width of each counter bus.
- A_LAST, 5, final value of a before the b phase begins; legal range 1..2**W-1.
- B_LAST, 6, final value of b before the c phase begins; legal range 1..2**W-1.
- C_LAST, 7, final value of c before done; legal range 1..2**W-1.
- CNT_W, 8, width of step_cnt.

Ports:
- clk  input  1  rising-edge clock, shared with the sequencer.
- reset  input  1  asynchronous, active-low reset.
- a  input  W  sequencer counter a.
- b  input  W  sequencer counter b.
- c  input  W  sequencer counter c.
- phase  output  3  current checker state encoding (package enum).
- done  output  1  high while in S_DONE.
- err  output  1  sticky; high while in S_ERR.
- err_code  output  3  first error detected; 0 = none.
- step_cnt  output  CNT_W  number of accepted increments; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_IDLE; prev_a, prev_b, prev_c = 0.
  - done=0, err=0, err_code=0, step_cnt=0.
- Sampling:
  - On each posedge, a/b/c are sampled and compared with prev_*. prev_* then update to the sampled values.
  - All outputs are registered and reflect the sample taken at that same edge.
- S_IDLE, first edge after reset release:
  - sample must be a=b=c=0; otherwise err_code=1 (INIT_NONZERO) and go to S_ERR.
  - if all zero, go to S_A.
- S_A (active counter a; b and c must hold):
  - a must equal prev_a+1 modulo 2**W; otherwise err_code=2 (BAD_STEP).
  - b or c changing gives err_code=3 (IDLE_MOVED).
  - A valid step increments step_cnt.
  - A valid step that lands on a==A_LAST goes to S_B.
- S_B: same rules with b active and a, c held; b==B_LAST goes to S_C.
- S_C: same rules with c active and a, b held; c==C_LAST goes to S_DONE.
- Stall: an active counter equal to prev (no step) is BAD_STEP. The sequencer steps every cycle, so a stall is an error.
- S_DONE:
  - done=1.
  - Any change on a, b or c gives err_code=4 (OVERRUN) and goes to S_ERR; done drops.
- Error priority within one sample: BAD_STEP > IDLE_MOVED.
- S_ERR:
  - terminal; err=1; err_code frozen at the first error; step_cnt frozen.
  - Leaves S_ERR only on reset.
- step_cnt saturates at 2**CNT_W-1 and does not wrap.
- Nominal run with default parameters gives step_cnt=18, and done rises 18 edges after the S_IDLE edge.
- Reset mid-run: immediate return to reset values. The next clean edge re-enters S_IDLE.
- phase encoding: S_IDLE=0, S_A=1, S_B=2, S_C=3, S_DONE=4, S_ERR=5.

Decomposition:
- Package abc_pkg holds:
  - typedef enum logic [2:0] state_t with the six states above.
  - typedef enum logic [2:0] err_t: NONE=0, INIT_NONZERO=1, BAD_STEP=2, IDLE_MOVED=3, OVERRUN=4.
  - constant W_DEF=3.
- Sub-module abc_step_check (combinational).
  - Inputs: cur, prev, active.
  - Outputs: ok_step (active and cur==prev+1) and moved (not active and cur!=prev).
  - Instantiated three times, once each for a, b, c.

Test Plan:
- Nominal sequence, default parameters: drive a 0..5, then b 0..6, then c 0..7, one step per cycle, then hold. Required: phase 1 then 2, 3, 4; done=1 after 18 steps; step_cnt=18; err=0.
- Nonzero start: first sample a=1, b=0, c=0. Required: err=1, err_code=1, phase=5, step_cnt=0.
- Skip in a: a goes 0,1,2,4. Required: err_code=2 on the edge sampling a=4; step_cnt=2; later activity is ignored.
- Idle counter moves: in S_A, sample a=3 with b=1. Required: err_code=2 (BAD_STEP) if a also mis-steps, else err_code=3; phase=5.
- Overrun: complete the nominal run, then change c to 0. Required: done falls, err_code=4, step_cnt stays 18.
- Async reset mid-run: assert reset low between edges during S_B. Required: immediate done=0, err=0, step_cnt=0, phase=0; a fresh nominal run then passes with step_cnt=18.
